unidad_de_busqueda: RTL and testbench
=====================================

Name: unidad_de_busqueda

Overview:
Instruction fetch/decode unit at the consumer end of the instruction address bus driven by the jump unit (program counter).
- Reads the current address and fetches a 16-bit instruction from instruction memory over a req/ack handshake.
- Decodes jump instructions into the jump unit's Direccion_de_Salto and Condicion inputs.
- Issues a one-cycle advance pulse; the PC steps only on that pulse (clock enable).

Parameters:
TIMEOUT, 15, max REQ cycles without i_Mem_Ack before fault (1..255)
OP_SALTO, 4'hA, opcode of conditional/unconditional jump
OP_ALTO, 4'h1, opcode of halt

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset, asynchronous, active-low (0 = reset)
i_Bus_Direcciones_Instrucciones  input  8  current PC from jump unit
o_Mem_Dir  output  8  instruction memory address
o_Mem_Req  output  1  read request, held until ack
i_Mem_Ack  input  1  memory ack; i_Mem_Dato valid this cycle
i_Mem_Dato  input  16  instruction word
o_Instruccion  output  16  instruction register
o_Instr_Valida  output  1  1-cycle pulse: o_Instruccion newly decoded
o_Direccion_de_Salto  output  8  jump target
o_Condicion  output  4  {jump_enable, cond[2:0]} to jump unit
o_Avance  output  1  1-cycle PC clock-enable pulse
o_Alto  output  1  halted (sticky)
o_Error  output  1  memory timeout (sticky)

Behaviour:
- Reset is asynchronous and active-low. While Rst=0: state=IDLE, all outputs 0, timeout counter 0. Rst may assert in any state; the effect is immediate and any pending fetch is abandoned.
- Instruction format: [15:12] opcode, [11] unused, [10:8] cond, [7:0] target.
- FSM states: IDLE, REQ, DECODE, SETTLE, HALT, ERROR.
- IDLE: on the first edge after Rst rises -> REQ. The same edge loads o_Mem_Dir <= i_Bus_Direcciones_Instrucciones, sets o_Mem_Req <= 1, and clears the counter.
- REQ: o_Mem_Req=1 and o_Mem_Dir is stable.
  - Ack=1 at an edge: o_Instruccion <= i_Mem_Dato; decoded outputs registered; o_Mem_Req <= 0; o_Instr_Valida <= 1; -> DECODE.
  - Ack=0 and counter==TIMEOUT: o_Mem_Req <= 0; o_Error <= 1; -> ERROR.
  - Ack=0 otherwise: counter++.
  - Ack=1 on the same edge as counter==TIMEOUT: the ack wins.
- Decode, registered on the ack edge:
  - Opcode==OP_SALTO: o_Condicion <= {1, cond}, o_Direccion_de_Salto <= target, o_Avance <= 1.
  - Opcode==OP_ALTO: o_Condicion <= 0, o_Direccion_de_Salto <= 0, o_Avance <= 0, o_Alto <= 1.
  - Any other opcode: o_Condicion <= 0, o_Direccion_de_Salto <= 0, o_Avance <= 1.
- DECODE (exactly 1 cycle): the outputs above are visible. Next edge: o_Avance, o_Instr_Valida, o_Condicion and o_Direccion_de_Salto <= 0. Then -> HALT if o_Alto, else -> SETTLE.
- SETTLE (1 cycle): lets the PC update on the o_Avance edge. Next edge: o_Mem_Dir <= i_Bus_Direcciones_Instrucciones, o_Mem_Req <= 1, counter <= 0, -> REQ.
- HALT and ERROR are terminal until reset. All pulses are 0; o_Mem_Req=0; o_Instruccion holds its value.
- i_Mem_Ack outside REQ is ignored.
- i_Mem_Dato is sampled only on the ack edge.
- o_Condicion is non-zero only during DECODE, so the jump unit never sees a stale condition.
- Fetch latency: ack at edge N gives outputs valid N..N+1 and the next request at edge N+2. Best-case throughput is one instruction per 3 cycles, with an ack-in-first-REQ-cycle memory.
- Address 8'hFF wrap to 8'h00 is handled by the PC. This block fetches whatever address is presented.

Test Plan:
- Reset/IDLE: hold Rst=0 for 3 cycles, release -> all outputs 0 during reset; o_Mem_Req=1, o_Mem_Dir=PC(=8'h00) one edge after release.
- Sequential fetch: memory acks in 1 cycle with 16'h2345 at 8'h00 -> o_Instruccion=16'h2345, o_Avance=1 for 1 cycle, o_Condicion=0; next request at o_Mem_Dir=8'h01 two edges later.
- Jump decode: i_Mem_Dato=16'hA340 -> o_Condicion=4'b1011, o_Direccion_de_Salto=8'h40 for exactly one cycle, then both 0.
- Wait states and timeout:
  - Ack delayed 5 cycles -> o_Mem_Req held high with o_Mem_Dir stable, no error.
  - Ack never arrives -> o_Error=1 after TIMEOUT+1 REQ cycles, o_Mem_Req=0, stays in ERROR.
  - Ack exactly on the TIMEOUT cycle -> fetch succeeds, o_Error=0.
- Halt: i_Mem_Dato=16'h1000 -> o_Alto=1, o_Avance never pulses, no further requests; reset clears o_Alto.
- Mid-fetch reset: drop Rst while o_Mem_Req=1 -> o_Mem_Req=0 immediately (before the next edge); a later spurious ack is ignored; fetch restarts cleanly after release.

Source files
------------

// File: rtl/unidad_de_busqueda_if.sv
// -----------------------------------------------------------------------------
// unidad_de_busqueda_if
// Instruction memory read bus between the fetch/decode unit and instruction
// memory. The fetch unit holds o_Mem_Req with a stable o_Mem_Dir until the
// memory answers with i_Mem_Ack; i_Mem_Dato is valid in the ack cycle only.
//
// Signals:
//   o_Mem_Dir   [7:0]   instruction memory address        (fetch -> memory)
//   o_Mem_Req           read request, held until ack       (fetch -> memory)
//   i_Mem_Ack           read acknowledge                   (memory -> fetch)
//   i_Mem_Dato  [15:0]  instruction word, valid with ack   (memory -> fetch)
//
// Modports:
//   master : the fetch unit (drives address and request)
//   slave  : the instruction memory (drives ack and data)
// -----------------------------------------------------------------------------
interface unidad_de_busqueda_if;
    logic [7:0]  o_Mem_Dir;
    logic        o_Mem_Req;
    logic        i_Mem_Ack;
    logic [15:0] i_Mem_Dato;

    modport master (
        output o_Mem_Dir,
        output o_Mem_Req,
        input  i_Mem_Ack,
        input  i_Mem_Dato
    );

    modport slave (
        input  o_Mem_Dir,
        input  o_Mem_Req,
        output i_Mem_Ack,
        output i_Mem_Dato
    );
endinterface

// File: rtl/unidad_de_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_de_busqueda
// Instruction fetch/decode unit. Reads the program counter presented by the
// jump unit, fetches the 16-bit instruction over the memory req/ack bus,
// decodes jump instructions into the jump unit's target/condition inputs and
// emits a one-cycle advance pulse that acts as the PC clock enable.
//
// Instruction word: [15:12] opcode, [11] unused, [10:8] cond, [7:0] target.
//
// Ports:
//   Clk                              system clock, rising edge
//   Rst                              asynchronous reset, active-low
//   mem                              instruction memory bus (master side)
//   i_Bus_Direcciones_Instrucciones  current PC from the jump unit
//   o_Instruccion                    last fetched instruction word
//   o_Instr_Valida                   1-cycle pulse: new instruction decoded
//   o_Direccion_de_Salto             jump target (non-zero only in DECODE)
//   o_Condicion                      {jump_enable, cond[2:0]} (only in DECODE)
//   o_Avance                         1-cycle PC clock-enable pulse
//   o_Alto                           halted, sticky until reset
//   o_Error                          memory timeout, sticky until reset
//
// Fetch cadence: ack at edge N -> decoded outputs visible N..N+1, SETTLE lets
// the PC step on the o_Avance edge, next request issued at edge N+2.
// -----------------------------------------------------------------------------
module unidad_de_busqueda #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [3:0]  OP_SALTO = 4'hA,
    parameter logic [3:0]  OP_ALTO  = 4'h1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    unidad_de_busqueda_if.master      mem,
    input  logic [7:0]                i_Bus_Direcciones_Instrucciones,
    output logic [15:0]               o_Instruccion,
    output logic                      o_Instr_Valida,
    output logic [7:0]                o_Direccion_de_Salto,
    output logic [3:0]                o_Condicion,
    output logic                      o_Avance,
    output logic                      o_Alto,
    output logic                      o_Error
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        DECODE = 3'd2,
        SETTLE = 3'd3,
        HALT   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [7:0]  dir_q, dir_d;
    logic        req_q, req_d;
    logic [15:0] instr_d;
    logic        valida_d;
    logic [7:0]  salto_d;
    logic [3:0]  cond_d;
    logic        avance_d;
    logic        alto_d;
    logic        error_d;

    assign mem.o_Mem_Dir = dir_q;
    assign mem.o_Mem_Req = req_q;

    // State and output registers. Every output is registered so the jump
    // unit and memory never see combinational glitches from this block.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state                <= IDLE;
            cnt                  <= 8'd0;
            dir_q                <= 8'd0;
            req_q                <= 1'b0;
            o_Instruccion        <= 16'd0;
            o_Instr_Valida       <= 1'b0;
            o_Direccion_de_Salto <= 8'd0;
            o_Condicion          <= 4'd0;
            o_Avance             <= 1'b0;
            o_Alto               <= 1'b0;
            o_Error              <= 1'b0;
        end else begin
            state                <= state_d;
            cnt                  <= cnt_d;
            dir_q                <= dir_d;
            req_q                <= req_d;
            o_Instruccion        <= instr_d;
            o_Instr_Valida       <= valida_d;
            o_Direccion_de_Salto <= salto_d;
            o_Condicion          <= cond_d;
            o_Avance             <= avance_d;
            o_Alto               <= alto_d;
            o_Error              <= error_d;
        end
    end

    // Next-state logic. The ack check comes before the timeout check so an
    // ack arriving on the last allowed cycle still completes the fetch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = REQ;
            REQ: begin
                if (mem.i_Mem_Ack)
                    state_d = DECODE;
                else if (cnt == TIMEOUT_C)
                    state_d = ERROR;
            end
            DECODE:  state_d = o_Alto ? HALT : SETTLE;
            SETTLE:  state_d = REQ;
            HALT:    state_d = HALT;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. Pulses and the jump fields
    // default to 0 so they are only ever non-zero for the DECODE cycle.
    always_comb begin
        cnt_d    = cnt;
        dir_d    = dir_q;
        req_d    = req_q;
        instr_d  = o_Instruccion;
        valida_d = 1'b0;
        salto_d  = 8'd0;
        cond_d   = 4'd0;
        avance_d = 1'b0;
        alto_d   = o_Alto;
        error_d  = o_Error;

        case (state)
            IDLE, SETTLE: begin
                // Launch a fetch of whatever address the PC presents now.
                dir_d = i_Bus_Direcciones_Instrucciones;
                req_d = 1'b1;
                cnt_d = 8'd0;
            end
            REQ: begin
                if (mem.i_Mem_Ack) begin
                    instr_d  = mem.i_Mem_Dato;
                    req_d    = 1'b0;
                    valida_d = 1'b1;
                    if (mem.i_Mem_Dato[15:12] == OP_SALTO) begin
                        cond_d   = {1'b1, mem.i_Mem_Dato[10:8]};
                        salto_d  = mem.i_Mem_Dato[7:0];
                        avance_d = 1'b1;
                    end else if (mem.i_Mem_Dato[15:12] == OP_ALTO) begin
                        alto_d   = 1'b1;
                    end else begin
                        avance_d = 1'b1;
                    end
                end else if (cnt == TIMEOUT_C) begin
                    req_d   = 1'b0;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidad_de_busqueda.sv
// -----------------------------------------------------------------------------
// tb_unidad_de_busqueda
// Drives unidad_de_busqueda with a jump-unit stand-in (PC register stepping on
// o_Avance) and a task-driven instruction memory. Expected addresses and
// decode results come from a per-instruction model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_unidad_de_busqueda;

    localparam int TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  pc;
    logic [15:0] o_Instruccion;
    logic        o_Instr_Valida;
    logic [7:0]  o_Direccion_de_Salto;
    logic [3:0]  o_Condicion;
    logic        o_Avance;
    logic        o_Alto;
    logic        o_Error;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_addr;

    unidad_de_busqueda_if mem_if ();

    always #5 Clk = ~Clk;

    unidad_de_busqueda #(
        .TIMEOUT  (TIMEOUT),
        .OP_SALTO (4'hA),
        .OP_ALTO  (4'h1)
    ) dut (
        .Clk                             (Clk),
        .Rst                             (Rst),
        .mem                             (mem_if),
        .i_Bus_Direcciones_Instrucciones (pc),
        .o_Instruccion                   (o_Instruccion),
        .o_Instr_Valida                  (o_Instr_Valida),
        .o_Direccion_de_Salto            (o_Direccion_de_Salto),
        .o_Condicion                     (o_Condicion),
        .o_Avance                        (o_Avance),
        .o_Alto                          (o_Alto),
        .o_Error                         (o_Error)
    );

    // Jump unit stand-in: PC steps only on o_Avance, any jump is taken.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            pc <= 8'd0;
        else if (o_Avance)
            pc <= o_Condicion[3] ? o_Direccion_de_Salto : pc + 8'd1;
    end

    typedef struct packed {
        logic [3:0] cond;
        logic [7:0] target;
        logic       avance;
        logic       alto;
    } dec_t;

    function automatic dec_t model_decode(input logic [15:0] w);
        dec_t r;
        r.cond = 4'd0; r.target = 8'd0; r.avance = 1'b1; r.alto = 1'b0;
        if (w[15:12] == 4'hA) begin
            r.cond = {1'b1, w[10:8]};
            r.target = w[7:0];
        end else if (w[15:12] == 4'h1) begin
            r.avance = 1'b0;
            r.alto = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] a, input logic [15:0] w);
        return (w[15:12] == 4'hA) ? w[7:0] : a + 8'd1;
    endfunction

    // Memory side: keeps ack low for 'delay' cycles (recording whether the
    // request stayed up with a stable address), then acks for one cycle.
    // Returns at the negedge following the ack edge.
    task automatic serve(input int delay, input logic [15:0] word, output bit held_ok);
        logic [7:0] dir0;
        dir0 = mem_if.o_Mem_Dir;
        held_ok = 1'b1;
        for (int i = 0; i < delay; i++) begin
            mem_if.i_Mem_Ack = 1'b0;
            @(negedge Clk);
            if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== dir0 || o_Error !== 1'b0)
                held_ok = 1'b0;
        end
        mem_if.i_Mem_Ack  = 1'b1;
        mem_if.i_Mem_Dato = word;
        @(negedge Clk);
        mem_if.i_Mem_Ack  = 1'b0;
        mem_if.i_Mem_Dato = 16'($urandom);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        exp_addr = 8'd0;
    endtask

    task automatic test_reset();
        mem_if.i_Mem_Ack  = 1'b0;
        mem_if.i_Mem_Dato = 16'd0;
        #1 Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if ({mem_if.o_Mem_Dir, mem_if.o_Mem_Req, o_Instruccion, o_Instr_Valida,
                 o_Direccion_de_Salto, o_Condicion, o_Avance, o_Alto, o_Error} !== 43'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d req=%b dir=%h instr=%h err=%b", i,
                         mem_if.o_Mem_Req, mem_if.o_Mem_Dir, o_Instruccion, o_Error);
            end
        end
        release_reset();
        checks++;
        if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== 8'h00 || o_Instr_Valida !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req got req=%b dir=%h valida=%b exp req=1 dir=00 valida=0",
                     mem_if.o_Mem_Req, mem_if.o_Mem_Dir, o_Instr_Valida);
        end
    endtask

    task automatic test_seq_fetch();
        bit ok;
        serve(0, 16'h2345, ok);
        checks++;
        if ({o_Instruccion, o_Avance, o_Instr_Valida, o_Condicion, mem_if.o_Mem_Req} !==
            {16'h2345, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL seq_decode got instr=%h av=%b val=%b cond=%h req=%b exp 2345 1 1 0 0",
                     o_Instruccion, o_Avance, o_Instr_Valida, o_Condicion, mem_if.o_Mem_Req);
        end
        exp_addr = model_next(exp_addr, 16'h2345);
        @(negedge Clk);
        checks++;
        if (o_Avance !== 1'b0 || o_Instr_Valida !== 1'b0 || mem_if.o_Mem_Req !== 1'b0) begin
            failures++;
            $display("FAIL seq_settle got av=%b val=%b req=%b exp 0 0 0",
                     o_Avance, o_Instr_Valida, mem_if.o_Mem_Req);
        end
        @(negedge Clk);
        checks++;
        if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== exp_addr) begin
            failures++;
            $display("FAIL seq_next_req got req=%b dir=%h exp req=1 dir=%h",
                     mem_if.o_Mem_Req, mem_if.o_Mem_Dir, exp_addr);
        end
    endtask

    task automatic test_jump();
        bit ok;
        serve(0, 16'hA340, ok);
        checks++;
        if (o_Condicion !== 4'b1011 || o_Direccion_de_Salto !== 8'h40 || o_Avance !== 1'b1) begin
            failures++;
            $display("FAIL jump_decode got cond=%b tgt=%h av=%b exp cond=1011 tgt=40 av=1",
                     o_Condicion, o_Direccion_de_Salto, o_Avance);
        end
        exp_addr = model_next(exp_addr, 16'hA340);
        @(negedge Clk);
        checks++;
        if (o_Condicion !== 4'd0 || o_Direccion_de_Salto !== 8'd0) begin
            failures++;
            $display("FAIL jump_clear got cond=%b tgt=%h exp 0 0", o_Condicion, o_Direccion_de_Salto);
        end
        @(negedge Clk);
        checks++;
        if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== exp_addr) begin
            failures++;
            $display("FAIL jump_target_req got req=%b dir=%h exp req=1 dir=%h",
                     mem_if.o_Mem_Req, mem_if.o_Mem_Dir, exp_addr);
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        serve(5, 16'h3000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_hold got held_ok=0 exp 1");
        end
        checks++;
        if (o_Instruccion !== 16'h3000 || o_Error !== 1'b0 || o_Instr_Valida !== 1'b1) begin
            failures++;
            $display("FAIL wait_fetch got instr=%h err=%b val=%b exp 3000 0 1",
                     o_Instruccion, o_Error, o_Instr_Valida);
        end
        exp_addr = model_next(exp_addr, 16'h3000);
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_random();
        bit ok;
        logic [15:0] w;
        int d;
        dec_t e;
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:12] = 4'hA;
            if (w[15:12] == 4'h1) w[15:12] = 4'h7;
            d = $urandom_range(0, 4);
            checks++;
            if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== exp_addr) begin
                failures++;
                $display("FAIL rnd_req n=%0d got req=%b dir=%h exp req=1 dir=%h",
                         n, mem_if.o_Mem_Req, mem_if.o_Mem_Dir, exp_addr);
            end
            serve(d, w, ok);
            e = model_decode(w);
            checks++;
            if ({ok, o_Instruccion, o_Instr_Valida, o_Avance, o_Condicion, o_Direccion_de_Salto,
                 mem_if.o_Mem_Req, o_Alto, o_Error} !==
                {1'b1, w, 1'b1, e.avance, e.cond, e.target, 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rnd_decode n=%0d w=%h got ok=%b instr=%h av=%b cond=%h tgt=%h exp av=%b cond=%h tgt=%h",
                         n, w, ok, o_Instruccion, o_Avance, o_Condicion, o_Direccion_de_Salto,
                         e.avance, e.cond, e.target);
            end
            exp_addr = model_next(exp_addr, w);
            @(negedge Clk);
            checks++;
            if ({o_Instr_Valida, o_Avance, o_Condicion, o_Direccion_de_Salto, mem_if.o_Mem_Req} !== 15'd0) begin
                failures++;
                $display("FAIL rnd_settle n=%0d got val=%b av=%b cond=%h tgt=%h req=%b exp all 0",
                         n, o_Instr_Valida, o_Avance, o_Condicion, o_Direccion_de_Salto, mem_if.o_Mem_Req);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_timeout_exact();
        bit ok;
        serve(TIMEOUT, 16'h4567, ok);
        checks++;
        if (!ok || o_Error !== 1'b0 || o_Instr_Valida !== 1'b1 || o_Instruccion !== 16'h4567) begin
            failures++;
            $display("FAIL timeout_exact got ok=%b err=%b val=%b instr=%h exp 1 0 1 4567",
                     ok, o_Error, o_Instr_Valida, o_Instruccion);
        end
        exp_addr = model_next(exp_addr, 16'h4567);
        repeat (2) @(negedge Clk);
        checks++;
        if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== exp_addr) begin
            failures++;
            $display("FAIL timeout_exact_next got req=%b dir=%h exp req=1 dir=%h",
                     mem_if.o_Mem_Req, mem_if.o_Mem_Dir, exp_addr);
        end
    endtask

    task automatic test_halt();
        bit ok;
        bit bad;
        serve(0, 16'h1000, ok);
        checks++;
        if (o_Alto !== 1'b1 || o_Avance !== 1'b0 || o_Instr_Valida !== 1'b1 || o_Condicion !== 4'd0) begin
            failures++;
            $display("FAIL halt_decode got alto=%b av=%b val=%b cond=%h exp 1 0 1 0",
                     o_Alto, o_Avance, o_Instr_Valida, o_Condicion);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (mem_if.o_Mem_Req !== 1'b0 || o_Avance !== 1'b0 || o_Alto !== 1'b1 ||
                o_Instr_Valida !== 1'b0 || o_Instruccion !== 16'h1000)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL halt_hold got req=%b av=%b alto=%b instr=%h exp 0 0 1 1000",
                     mem_if.o_Mem_Req, o_Avance, o_Alto, o_Instruccion);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (o_Alto !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset_clear got alto=%b exp 0", o_Alto);
        end
        release_reset();
    endtask

    task automatic test_timeout();
        bit bad;
        bad = (mem_if.o_Mem_Req !== 1'b1) || (o_Error !== 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge Clk);
            if (mem_if.o_Mem_Req !== 1'b1 || o_Error !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout_window got early error or dropped req (req=%b err=%b) exp req=1 err=0",
                     mem_if.o_Mem_Req, o_Error);
        end
        @(negedge Clk);
        checks++;
        if (o_Error !== 1'b1 || mem_if.o_Mem_Req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_error got err=%b req=%b exp err=1 req=0", o_Error, mem_if.o_Mem_Req);
        end
        mem_if.i_Mem_Ack  = 1'b1;
        mem_if.i_Mem_Dato = 16'h2222;
        repeat (3) @(negedge Clk);
        mem_if.i_Mem_Ack = 1'b0;
        checks++;
        if (o_Error !== 1'b1 || mem_if.o_Mem_Req !== 1'b0 || o_Instr_Valida !== 1'b0 || o_Avance !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b req=%b val=%b av=%b exp 1 0 0 0",
                     o_Error, mem_if.o_Mem_Req, o_Instr_Valida, o_Avance);
        end
        Rst = 1'b0;
        release_reset();
    endtask

    task automatic test_mid_reset();
        bit ok;
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        checks++;
        if (mem_if.o_Mem_Req !== 1'b0 || Clk !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async got req=%b clk=%b exp req=0 clk=0", mem_if.o_Mem_Req, Clk);
        end
        mem_if.i_Mem_Ack  = 1'b1;
        mem_if.i_Mem_Dato = 16'h1000;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        mem_if.i_Mem_Ack = 1'b0;
        exp_addr = 8'd0;
        checks++;
        if (mem_if.o_Mem_Req !== 1'b1 || mem_if.o_Mem_Dir !== 8'h00 || o_Instruccion !== 16'd0 ||
            o_Instr_Valida !== 1'b0 || o_Alto !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart got req=%b dir=%h instr=%h val=%b alto=%b exp 1 00 0000 0 0",
                     mem_if.o_Mem_Req, mem_if.o_Mem_Dir, o_Instruccion, o_Instr_Valida, o_Alto);
        end
        serve(1, 16'h5ABC, ok);
        checks++;
        if (!ok || o_Instruccion !== 16'h5ABC || o_Avance !== 1'b1 || o_Alto !== 1'b0) begin
            failures++;
            $display("FAIL midreset_fetch got ok=%b instr=%h av=%b alto=%b exp 1 5abc 1 0",
                     ok, o_Instruccion, o_Avance, o_Alto);
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_jump();
        test_wait_states();
        test_random();
        test_timeout_exact();
        test_halt();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
